// File: rtl/ps2_host_tx.sv
//============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (request-to-send,
//               11-bit frame, device ACK, bus-idle wait, timeout).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000,
    parameter int FILT        = 8
) (
    input  logic       m_clock,
    input  logic       p_reset_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       clk_oe,
    output logic       dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int c_inh_w = $clog2(INHIBIT_CYC + 1);
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);
    localparam int c_flt_w = $clog2(FILT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [1:0]           r_clk_sync_q, w_clk_sync_d;
    logic [1:0]           r_dat_sync_q, w_dat_sync_d;
    logic                 r_filt_q, w_filt_d;
    logic [c_flt_w-1:0]   r_filt_cnt_q, w_filt_cnt_d;
    logic [c_inh_w-1:0]   r_inh_cnt_q, w_inh_cnt_d;
    logic [c_tmo_w-1:0]   r_tmo_cnt_q, w_tmo_cnt_d;
    logic [3:0]           r_n_q, w_n_d;
    logic [8:0]           r_shift_q, w_shift_d;
    logic                 r_ack_ok_q, w_ack_ok_d;
    logic                 r_err_q, w_err_d;

    logic w_clk_s;
    logic w_dat_s;
    logic w_fe;
    logic w_tmo_hit;

    assign w_clk_s = r_clk_sync_q[1];
    assign w_dat_s = r_dat_sync_q[1];

    // Synchronizers and CLK glitch filter: the level flips only after FILT
    // consecutive samples disagree with it.
    always_comb begin
        w_clk_sync_d = {r_clk_sync_q[0], ps2_clk_in};
        w_dat_sync_d = {r_dat_sync_q[0], ps2_dat_in};
        w_filt_d     = r_filt_q;
        w_filt_cnt_d = '0;
        w_fe         = 1'b0;
        if (w_clk_s != r_filt_q) begin
            if (r_filt_cnt_q == c_flt_w'(FILT - 1)) begin
                w_filt_d = w_clk_s;
                w_fe     = r_filt_q;
            end else begin
                w_filt_cnt_d = r_filt_cnt_q + c_flt_w'(1);
            end
        end
    end

    assign w_tmo_hit = (r_tmo_cnt_q == c_tmo_w'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_d   = r_state_q;
        w_inh_cnt_d = r_inh_cnt_q;
        w_tmo_cnt_d = r_tmo_cnt_q;
        w_n_d       = r_n_q;
        w_shift_d   = r_shift_q;
        w_ack_ok_d  = r_ack_ok_q;
        w_err_d     = r_err_q;
        clk_oe      = 1'b0;
        dat_oe      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (tx_start) begin
                    w_shift_d   = {~^tx_data, tx_data};
                    w_ack_ok_d  = 1'b0;
                    w_err_d     = 1'b0;
                    w_inh_cnt_d = '0;
                    w_state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                busy   = 1'b1;
                clk_oe = 1'b1;
                if (r_inh_cnt_q == c_inh_w'(INHIBIT_CYC - 1)) begin
                    w_inh_cnt_d = '0;
                    w_state_d   = S_START;
                end else begin
                    w_inh_cnt_d = r_inh_cnt_q + c_inh_w'(1);
                end
            end
            S_START: begin
                busy        = 1'b1;
                clk_oe      = 1'b1;
                dat_oe      = 1'b1;
                w_tmo_cnt_d = '0;
                w_n_d       = '0;
                w_state_d   = S_SEND;
            end
            S_SEND: begin
                busy   = 1'b1;
                // n==0 is still the start bit; afterwards shift[0] is on the wire
                dat_oe = (r_n_q == 4'd0) ? 1'b1 : ~r_shift_q[0];
                if (w_tmo_hit) begin
                    w_err_d    = 1'b1;
                    w_ack_ok_d = 1'b0;
                    w_state_d  = S_DONE;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt_q + c_tmo_w'(1);
                    if (w_fe) begin
                        w_n_d = r_n_q + 4'd1;
                        if (r_n_q != 4'd0) begin
                            w_shift_d = {1'b1, r_shift_q[8:1]};
                        end
                        if (r_n_q == 4'd9) begin
                            w_state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                busy = 1'b1;
                if (w_tmo_hit) begin
                    w_err_d    = 1'b1;
                    w_ack_ok_d = 1'b0;
                    w_state_d  = S_DONE;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt_q + c_tmo_w'(1);
                    if (w_fe) begin
                        w_n_d      = r_n_q + 4'd1;
                        w_ack_ok_d = ~w_dat_s;
                        w_state_d  = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                busy = 1'b1;
                if (w_tmo_hit) begin
                    w_err_d    = 1'b1;
                    w_ack_ok_d = 1'b0;
                    w_state_d  = S_DONE;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt_q + c_tmo_w'(1);
                    if (r_filt_q && w_dat_s) begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_clock) begin
        if (!p_reset_n) begin
            r_state_q    <= S_IDLE;
            r_clk_sync_q <= 2'b11;
            r_dat_sync_q <= 2'b11;
            r_filt_q     <= 1'b1;
            r_filt_cnt_q <= '0;
            r_inh_cnt_q  <= '0;
            r_tmo_cnt_q  <= '0;
            r_n_q        <= '0;
            r_shift_q    <= '0;
            r_ack_ok_q   <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_clk_sync_q <= w_clk_sync_d;
            r_dat_sync_q <= w_dat_sync_d;
            r_filt_q     <= w_filt_d;
            r_filt_cnt_q <= w_filt_cnt_d;
            r_inh_cnt_q  <= w_inh_cnt_d;
            r_tmo_cnt_q  <= w_tmo_cnt_d;
            r_n_q        <= w_n_d;
            r_shift_q    <= w_shift_d;
            r_ack_ok_q   <= w_ack_ok_d;
            r_err_q      <= w_err_d;
        end
    end

    assign ack_ok = r_ack_ok_q;
    assign err    = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
//============================================================================
// Module      : tb_ps2_host_tx
// Description : Directed self-checking bench for ps2_host_tx with a simple
//               open-drain bus and PS/2 device model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ps2_host_tx;

    localparam int INH = 16;
    localparam int TMO = 200;
    localparam int FLT = 4;
    // Device clock phases, scaled down so a frame fits well inside TMO.
    localparam int HI  = 5;
    localparam int LO  = 8;

    // Sample i of the 11-bit frame is bit i: start, d0..d7, parity, stop.
    localparam logic [10:0] FR_ED = 11'b111_1101_1010;
    localparam logic [10:0] FR_01 = 11'b100_0000_0010;
    localparam logic [10:0] FR_00 = 11'b110_0000_0000;
    localparam logic [10:0] FR_F4 = 11'b101_1110_1000;

    logic       m_clock   = 1'b0;
    logic       p_reset_n = 1'b0;
    logic       tx_start  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       dev_clk   = 1'b1;
    logic       dev_dat   = 1'b1;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       clk_oe, dat_oe, busy, done, ack_ok, err;

    int checks = 0;
    int errors = 0;

    assign ps2_clk_in = dev_clk & ~clk_oe;
    assign ps2_dat_in = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TMO),
        .FILT        (FLT)
    ) u_dut (
        .m_clock    (m_clock),
        .p_reset_n  (p_reset_n),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_oe     (clk_oe),
        .dat_oe     (dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .err        (err)
    );

    always #5 m_clock = ~m_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request a transfer and measure the clock-inhibit window.
    task automatic send_start(input logic [7:0] d);
        int cnt;
        int first;
        @(negedge m_clock);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge m_clock);
        tx_start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        cnt   = 0;
        first = -1;
        while (clk_oe && cnt < 100) begin
            if (dat_oe && first < 0) first = cnt;
            cnt++;
            @(negedge m_clock);
        end
        check("clk_oe_len", cnt, INH + 1);
        check("dat_oe_rise", first, INH);
    endtask

    // Device: sample DATA at the end of each high phase, then pulse CLK low.
    task automatic dev_frame(input logic ack, input int glitch_bit, input int start_bit,
                             input int nbits, output logic [10:0] smp);
        smp = '0;
        for (int i = 0; i < nbits; i++) begin
            repeat (HI) @(negedge m_clock);
            if (i == glitch_bit) begin
                dev_clk = 1'b0;
                repeat (3) @(negedge m_clock);
                dev_clk = 1'b1;
                repeat (HI) @(negedge m_clock);
            end
            if (i == start_bit) begin
                tx_start = 1'b1;
                tx_data  = 8'h55;
                @(negedge m_clock);
                tx_start = 1'b0;
            end
            smp[i] = ps2_dat_in;
            if (i == 10 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            repeat (LO) @(negedge m_clock);
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input string tag, input logic exp_ack, input logic exp_err);
        int k;
        k = 0;
        while (!done && k < 60) begin
            @(negedge m_clock);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ack_err"}, 32'({ack_ok, err}), 32'({exp_ack, exp_err}));
        check({tag, "_busy_lines"}, 32'({busy, clk_oe, dat_oe}), 32'd0);
        @(negedge m_clock);
        check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [10:0] smp;
        int          cnt;
        int          k;

        repeat (3) @(negedge m_clock);
        check("reset_outputs", 32'({clk_oe, dat_oe, busy, done, ack_ok, err}), 32'd0);
        p_reset_n = 1'b1;
        repeat (4) @(negedge m_clock);
        check("idle_outputs", 32'({clk_oe, dat_oe, busy, done, ack_ok, err}), 32'd0);

        send_start(8'hED);
        dev_frame(1'b1, -1, -1, 11, smp);
        check("frame_ED", 32'(smp), 32'(FR_ED));
        wait_done("ED", 1'b1, 1'b0);

        send_start(8'h01);
        dev_frame(1'b1, -1, -1, 11, smp);
        check("frame_01", 32'(smp), 32'(FR_01));
        wait_done("01", 1'b1, 1'b0);

        send_start(8'h00);
        dev_frame(1'b1, -1, -1, 11, smp);
        check("frame_00", 32'(smp), 32'(FR_00));
        wait_done("00", 1'b1, 1'b0);

        send_start(8'hF4);
        dev_frame(1'b0, -1, -1, 11, smp);
        check("frame_nack", 32'(smp), 32'(FR_F4));
        wait_done("nack", 1'b0, 1'b0);

        // Silent device: host must give up after TMO cycles of SEND.
        send_start(8'hFF);
        cnt = 0;
        k   = 0;
        while (!done && k < 400) begin
            if (!clk_oe && dat_oe) cnt++;
            k++;
            @(negedge m_clock);
        end
        check("timeout_len", cnt, TMO);
        wait_done("timeout", 1'b0, 1'b1);

        // CLK glitch in bit 3 and a stray request during bit 6.
        send_start(8'hED);
        dev_frame(1'b1, 3, 6, 11, smp);
        check("frame_glitch_busy", 32'(smp), 32'(FR_ED));
        wait_done("glitch", 1'b1, 1'b0);
        repeat (5) @(negedge m_clock);
        check("no_stray_start", 32'({busy, clk_oe}), 32'd0);

        // Reset in the middle of a frame, then a clean transfer.
        send_start(8'hED);
        dev_frame(1'b1, -1, -1, 4, smp);
        check("mid_frame_driving", 32'(busy), 32'd1);
        p_reset_n = 1'b0;
        @(negedge m_clock);
        check("mid_frame_reset", 32'({clk_oe, dat_oe, busy, done, ack_ok, err}), 32'd0);
        p_reset_n = 1'b1;
        repeat (10) @(negedge m_clock);
        send_start(8'hF4);
        dev_frame(1'b1, -1, -1, 11, smp);
        check("frame_after_reset", 32'(smp), 32'(FR_F4));
        wait_done("after_reset", 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
